// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//
// Gathers completion results from NUM_SRC execution units and feeds the
// reorder buffer's single writeback port at up to one result per cycle.
//
// Each source owns a DEPTH-entry FIFO. A round-robin arbiter picks one
// non-empty FIFO per cycle, and the picked head entry is registered onto the
// wb_* outputs. A ROB flush empties every FIFO and suppresses writeback for
// that edge.
//
// Handshake (valid/ready, per source):
//   A transfer happens on a rising clk edge when src_valid[i] and src_ready[i]
//   are both high and rob_flush is low. src_ready[i] depends only on
//   registered FIFO occupancy, so it never depends combinationally on
//   src_valid or on the arbiter. A source may keep src_valid high with stable
//   data until it sees ready. wb_valid has no ready: the ROB always accepts.
//
// Ports:
//   clk         clock
//   rst_n       asynchronous active-low reset
//   src_valid   [NUM_SRC]      per-source result valid
//   src_ready   [NUM_SRC]      per-source FIFO not full
//   src_error   [NUM_SRC]      per-source exception flag
//   src_ecause  [NUM_SRC*5]    per-source exception cause, source i at [5i+4:5i]
//   src_robid   [NUM_SRC*7]    per-source ROB id, source i at [7i+6:7i]
//   src_result  [NUM_SRC*32]   per-source result, source i at [32i+31:32i]
//   rob_flush   discard every buffered result and any same-cycle push
//   wb_valid    writeback valid to the ROB
//   wb_error    exception flag of the written-back result
//   wb_ecause   exception cause
//   wb_robid    ROB id
//   wb_result   result data
// -----------------------------------------------------------------------------
module wb_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int DEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_SRC-1:0]    src_valid,
    output logic [NUM_SRC-1:0]    src_ready,
    input  logic [NUM_SRC-1:0]    src_error,
    input  logic [NUM_SRC*5-1:0]  src_ecause,
    input  logic [NUM_SRC*7-1:0]  src_robid,
    input  logic [NUM_SRC*32-1:0] src_result,
    input  logic                  rob_flush,
    output logic                  wb_valid,
    output logic                  wb_error,
    output logic [4:0]            wb_ecause,
    output logic [6:0]            wb_robid,
    output logic [31:0]           wb_result
);

    // FIFO index width and pointer width (index plus a wrap bit).
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    // Source index width.
    localparam int SW = $clog2(NUM_SRC);

    localparam logic [PW-1:0] FULL_COUNT = PW'(DEPTH);
    localparam logic [SW:0]   NSRC       = (SW + 1)'(NUM_SRC);
    localparam logic [SW-1:0] RR_RESET   = SW'(NUM_SRC - 1);

    typedef struct packed {
        logic        error;
        logic [4:0]  ecause;
        logic [6:0]  robid;
        logic [31:0] result;
    } entry_t;

    // -------------------------------------------------------------------------
    // Cross-source signals
    // -------------------------------------------------------------------------
    entry_t [NUM_SRC-1:0] head_entry;   // current head of each FIFO
    logic   [NUM_SRC-1:0] not_empty;    // arbitration candidates
    logic   [NUM_SRC-1:0] push;
    logic   [NUM_SRC-1:0] pop;

    logic                 grant_any;
    logic [SW-1:0]        grant_idx;
    logic [SW-1:0]        rr;           // index of the last granted source
    logic [SW:0]          cand;         // search position, one spare bit for the wrap

    // A grant only becomes a pop when the flush is not discarding everything.
    logic                 take;
    assign take = grant_any & ~rob_flush;

    // -------------------------------------------------------------------------
    // Per-source FIFOs
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [PW-1:0] head;
        logic [PW-1:0] tail;
        logic [PW-1:0] count;
        entry_t        entry_in;
        entry_t        mem [DEPTH];

        assign entry_in = {src_error[i],
                           src_ecause[5*i +: 5],
                           src_robid[7*i +: 7],
                           src_result[32*i +: 32]};

        // Pointer difference modulo 2*DEPTH is the occupancy: equal pointers
        // mean empty, equal indices with opposite wrap bits mean full.
        assign count         = tail - head;
        assign src_ready[i]  = (count != FULL_COUNT);
        assign not_empty[i]  = (head != tail);
        assign head_entry[i] = mem[head[IW-1:0]];

        assign push[i] = src_valid[i] & src_ready[i] & ~rob_flush;
        assign pop[i]  = take & (grant_idx == SW'(i));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                head <= '0;
                tail <= '0;
            end else if (rob_flush) begin
                // Emptying by catching head up to tail keeps both pointers
                // consistent without touching the storage.
                head <= tail;
            end else begin
                if (push[i]) tail <= tail + PW'(1);
                if (pop[i])  head <= head + PW'(1);
            end
        end

        // Storage carries no reset: an entry is only read after being written.
        always_ff @(posedge clk) begin
            if (push[i]) mem[tail[IW-1:0]] <= entry_in;
        end
    end

    // -------------------------------------------------------------------------
    // Round-robin arbiter: scan from rr+1 upward, wrapping, and grant the
    // first non-empty FIFO. The scan ends at rr itself, so the source granted
    // last has the lowest priority next time.
    // -------------------------------------------------------------------------
    always_comb begin
        grant_any = 1'b0;
        grant_idx = rr;
        cand      = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = {1'b0, rr} + (SW + 1)'(k);
            if (cand >= NSRC) cand = cand - NSRC;
            if (!grant_any && not_empty[cand[SW-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[SW-1:0];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Writeback register and arbiter pointer
    // -------------------------------------------------------------------------
    entry_t granted;
    assign granted = head_entry[grant_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr        <= RR_RESET;
            wb_valid  <= 1'b0;
            wb_error  <= 1'b0;
            wb_ecause <= '0;
            wb_robid  <= '0;
            wb_result <= '0;
        end else begin
            wb_valid <= take;
            // Payload holds its old value on idle cycles; only wb_valid
            // qualifies it.
            if (take) begin
                rr        <= grant_idx;
                wb_error  <= granted.error;
                wb_ecause <= granted.ecause;
                wb_robid  <= granted.robid;
                wb_result <= granted.result;
            end
        end
    end

endmodule
